// File: rtl/sdram_core_param.sv
// SDRAM command sequencer: power-up init, periodic auto-refresh and single-burst read/write.
// Define SDRAM_AUTO_PRE_EN to close rows with auto-precharge (a10 on READ/WRITE) instead of an explicit PRE.
module sdram_core_param #(
  parameter int unsigned INIT_CYC = 26600,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_RFC    = 9,
  parameter int unsigned T_MRD    = 2,
  parameter int unsigned T_RCD    = 3,
  parameter int unsigned T_WR     = 2,
  parameter int unsigned CL       = 3,
  parameter int unsigned BL       = 4,
  parameter int unsigned REF_CYC  = 1040
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  output logic       wr_ack,
  output logic       rd_ack,
  output logic       wr_data_valid,
  output logic       rd_data_valid,
  output logic [3:0] cmd,
  output logic       a10,
  output logic       init_done,
  output logic       ref_ack,
  output logic       busy
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AR    = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [3:0] S_POWER_ON  = 4'd0;
  localparam logic [3:0] S_INIT_NOP  = 4'd1;
  localparam logic [3:0] S_INIT_RP   = 4'd2;
  localparam logic [3:0] S_INIT_RFC1 = 4'd3;
  localparam logic [3:0] S_INIT_RFC2 = 4'd4;
  localparam logic [3:0] S_INIT_MRD  = 4'd5;
  localparam logic [3:0] S_IDLE      = 4'd6;
  localparam logic [3:0] S_ACT_WAIT  = 4'd7;
  localparam logic [3:0] S_RD_DATA   = 4'd8;
  localparam logic [3:0] S_WR_DATA   = 4'd9;
  localparam logic [3:0] S_PRE_WAIT  = 4'd10;
  localparam logic [3:0] S_REF_WAIT  = 4'd11;

  // Cycles after the last data beat that belong to the access itself before IDLE or PRE.
`ifdef SDRAM_AUTO_PRE_EN
  localparam logic        AUTO_PRE = 1'b1;
  localparam int unsigned RD_TAIL  = T_RP - 1;
  localparam int unsigned WR_TAIL  = T_WR + T_RP;
`else
  localparam logic        AUTO_PRE = 1'b0;
  localparam int unsigned RD_TAIL  = 0;
  localparam int unsigned WR_TAIL  = T_WR;
`endif

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
  localparam logic [15:0] RP_LAST   = 16'(T_RP - 1);
  localparam logic [15:0] RFC_LAST  = 16'(T_RFC - 1);
  localparam logic [15:0] MRD_LAST  = 16'(T_MRD - 1);
  localparam logic [15:0] RCD_LAST  = 16'(T_RCD - 1);
  localparam logic [15:0] RD_LAST   = 16'(CL + BL + RD_TAIL - 1);
  localparam logic [15:0] WR_LAST   = 16'(BL + WR_TAIL - 2);
  localparam logic [15:0] RD_LO     = 16'(RD_TAIL);
  localparam logic [15:0] RD_HI     = 16'(RD_TAIL + BL);
  localparam logic [15:0] WR_LO     = 16'(WR_TAIL);
  localparam logic [15:0] REF_LAST  = 16'(REF_CYC - 1);

  logic [3:0]  state;
  logic [15:0] cnt;
  logic [15:0] ref_timer;
  logic        ref_pending;
  logic        is_wr;

  assign busy = !(state == S_IDLE && init_done);

  // NOTE: every register here uses <= so all branches see pre-edge values; the
  // asynchronous reset sits in the sensitivity list so outputs clear without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_POWER_ON;
      cnt           <= '0;
      is_wr         <= 1'b0;
      cmd           <= CMD_NOP;
      a10           <= 1'b0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      ref_ack       <= 1'b0;
      wr_data_valid <= 1'b0;
      rd_data_valid <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      cmd           <= CMD_NOP;
      a10           <= 1'b0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      ref_ack       <= 1'b0;
      wr_data_valid <= 1'b0;
      rd_data_valid <= 1'b0;
      case (state)
        S_POWER_ON: begin
          cnt   <= INIT_LAST;
          state <= S_INIT_NOP;
        end
        S_INIT_NOP: begin
          if (cnt == 16'd0) begin
            cmd   <= CMD_PRE;
            a10   <= 1'b1;
            cnt   <= RP_LAST;
            state <= S_INIT_RP;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_RP, S_INIT_RFC1: begin
          if (cnt == 16'd0) begin
            cmd   <= CMD_AR;
            cnt   <= RFC_LAST;
            state <= (state == S_INIT_RP) ? S_INIT_RFC1 : S_INIT_RFC2;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_RFC2: begin
          if (cnt == 16'd0) begin
            cmd   <= CMD_MRS;
            cnt   <= MRD_LAST;
            state <= S_INIT_MRD;
          end else cnt <= cnt - 16'd1;
        end
        S_INIT_MRD: begin
          if (cnt == 16'd0) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else cnt <= cnt - 16'd1;
        end
        S_IDLE: begin
          if (ref_pending) begin
            cmd     <= CMD_AR;
            ref_ack <= 1'b1;
            cnt     <= RFC_LAST;
            state   <= S_REF_WAIT;
          end else if (wr_req || rd_req) begin
            cmd   <= CMD_ACT;
            is_wr <= wr_req;
            cnt   <= RCD_LAST;
            state <= S_ACT_WAIT;
          end
        end
        S_ACT_WAIT: begin
          if (cnt == 16'd0) begin
            a10 <= AUTO_PRE;
            if (is_wr) begin
              cmd           <= CMD_WRITE;
              wr_ack        <= 1'b1;
              wr_data_valid <= 1'b1;
              cnt           <= WR_LAST;
              state         <= S_WR_DATA;
            end else begin
              cmd    <= CMD_READ;
              rd_ack <= 1'b1;
              cnt    <= RD_LAST;
              state  <= S_RD_DATA;
            end
          end else cnt <= cnt - 16'd1;
        end
        S_RD_DATA, S_WR_DATA: begin
          // One counter spans latency, beats and the post-burst tail; the beat window is a count range.
          if (state == S_RD_DATA) rd_data_valid <= (cnt > RD_LO) && (cnt <= RD_HI);
          else                    wr_data_valid <= (cnt >= WR_LO);
          if (cnt == 16'd0) begin
`ifdef SDRAM_AUTO_PRE_EN
            state <= S_IDLE;
`else
            cmd   <= CMD_PRE;
            cnt   <= RP_LAST;
            state <= S_PRE_WAIT;
`endif
          end else cnt <= cnt - 16'd1;
        end
        S_PRE_WAIT, S_REF_WAIT: begin
          if (cnt == 16'd0) state <= S_IDLE;
          else              cnt   <= cnt - 16'd1;
        end
        default: state <= S_POWER_ON;
      endcase
    end
  end

  // Refresh timer: an expiry landing on the AR-issue edge re-arms the request rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
    end else if (init_done) begin
      if (ref_timer == REF_LAST) begin
        ref_timer   <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_timer <= ref_timer + 16'd1;
        if (state == S_IDLE && ref_pending) ref_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_core_param.sv
// Bench for sdram_core_param: an event-timeline reference model predicts every output on every cycle
// under directed and $urandom request traffic, including a reset dropped into a write burst.
module tb_sdram_core_param;
  localparam int INIT_CYC = 10;
  localparam int T_RP     = 3;
  localparam int T_RFC    = 7;
  localparam int T_MRD    = 2;
  localparam int T_RCD    = 3;
  localparam int T_WR     = 2;
  localparam int CL       = 3;
  localparam int BL       = 4;
  localparam int REF_CYC  = 100;
  localparam int MAXC     = 4096;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] READ  = 4'b0101;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] PRE   = 4'b0010;
  localparam logic [3:0] AR    = 4'b0001;
  localparam logic [3:0] MRS   = 4'b0000;

`ifdef SDRAM_AUTO_PRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_ack, rd_ack, wr_data_valid, rd_data_valid;
  logic [3:0] cmd;
  logic       a10, init_done, ref_ack, busy;

  sdram_core_param #(
    .INIT_CYC(INIT_CYC), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD), .T_RCD(T_RCD),
    .T_WR(T_WR), .CL(CL), .BL(BL), .REF_CYC(REF_CYC)
  ) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_data_valid(wr_data_valid), .rd_data_valid(rd_data_valid),
    .cmd(cmd), .a10(a10), .init_done(init_done), .ref_ack(ref_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected timeline, indexed by cycle number since reset release.
  logic [3:0] e_cmd    [MAXC];
  logic       e_a10    [MAXC];
  logic       e_wrv    [MAXC];
  logic       e_rdv    [MAXC];
  logic       e_wack   [MAXC];
  logic       e_rack   [MAXC];
  logic       e_refack [MAXC];
  int idle_from, next_idle, last_ar;

  function automatic void model_reset();
    for (int k = 0; k < MAXC; k++) begin
      e_cmd[k] = NOP; e_a10[k] = 1'b0; e_wrv[k] = 1'b0; e_rdv[k] = 1'b0;
      e_wack[k] = 1'b0; e_rack[k] = 1'b0; e_refack[k] = 1'b0;
    end
    e_cmd[INIT_CYC]               = PRE;
    e_a10[INIT_CYC]               = 1'b1;
    e_cmd[INIT_CYC+T_RP]          = AR;
    e_cmd[INIT_CYC+T_RP+T_RFC]    = AR;
    e_cmd[INIT_CYC+T_RP+2*T_RFC]  = MRS;
    idle_from = INIT_CYC + T_RP + 2*T_RFC + T_MRD;
    next_idle = idle_from;
    last_ar   = -1;
  endfunction

  // Refresh expiries fall every REF_CYC cycles counted from the cycle init_done rises.
  function automatic bit ref_pending_at(input int k);
    int latest;
    if (k < idle_from + REF_CYC) return 1'b0;
    latest = idle_from + ((k - idle_from) / REF_CYC) * REF_CYC;
    return latest >= last_ar;
  endfunction

  function automatic void model_step(input int k, input bit wr, input bit rd);
    int a, c, last;
    if (k < next_idle) return;
    a = k + 1;
    if (ref_pending_at(k)) begin
      e_cmd[a] = AR; e_refack[a] = 1'b1;
      last_ar = a;
      next_idle = a + T_RFC;
    end else if (wr) begin
      c = a + T_RCD;
      e_cmd[a] = ACT; e_cmd[c] = WRITE; e_wack[c] = 1'b1; e_a10[c] = AUTO;
      for (int i = 0; i < BL; i++) e_wrv[c+i] = 1'b1;
      last = c + BL - 1;
      if (!AUTO) e_cmd[last+T_WR] = PRE;
      next_idle = last + T_WR + T_RP;
    end else if (rd) begin
      c = a + T_RCD;
      e_cmd[a] = ACT; e_cmd[c] = READ; e_rack[c] = 1'b1; e_a10[c] = AUTO;
      for (int i = 0; i < BL; i++) e_rdv[c+CL+i] = 1'b1;
      last = c + CL + BL - 1;
      if (AUTO) next_idle = last + T_RP;
      else begin
        e_cmd[last+1] = PRE;
        next_idle = last + 1 + T_RP;
      end
    end
  endfunction

  // One cycle: compare all outputs, update held requests, advance the model.
  task automatic step(input bit raise_wr, input bit raise_rd);
    @(negedge clk);
    cyc++;
    check($sformatf("cmd@%0d", cyc), cmd, e_cmd[cyc]);
    check($sformatf("a10@%0d", cyc), a10, e_a10[cyc]);
    check($sformatf("wr_data_valid@%0d", cyc), wr_data_valid, e_wrv[cyc]);
    check($sformatf("rd_data_valid@%0d", cyc), rd_data_valid, e_rdv[cyc]);
    check($sformatf("wr_ack@%0d", cyc), wr_ack, e_wack[cyc]);
    check($sformatf("rd_ack@%0d", cyc), rd_ack, e_rack[cyc]);
    check($sformatf("ref_ack@%0d", cyc), ref_ack, e_refack[cyc]);
    check($sformatf("busy@%0d", cyc), busy, (cyc >= next_idle) ? 1'b0 : 1'b1);
    check($sformatf("init_done@%0d", cyc), init_done, (cyc >= idle_from) ? 1'b1 : 1'b0);
    if (wr_ack === 1'b1) wr_req = 1'b0;
    if (rd_ack === 1'b1) rd_req = 1'b0;
    if (raise_wr) wr_req = 1'b1;
    if (raise_rd) rd_req = 1'b1;
    model_step(cyc, wr_req, rd_req);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd"}, cmd, NOP);
    check({tag, "_a10"}, a10, 1'b0);
    check({tag, "_wrv"}, wr_data_valid, 1'b0);
    check({tag, "_rdv"}, rd_data_valid, 1'b0);
    check({tag, "_wack"}, wr_ack, 1'b0);
    check({tag, "_rack"}, rd_ack, 1'b0);
    check({tag, "_refack"}, ref_ack, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  initial begin
    bit rw, rr, seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    cyc = -1;
    model_reset();

    // Directed: lone read, simultaneous write+read, read straddling the first refresh expiry; then random.
    for (int i = 0; i < 1700; i++) begin
      rw = 1'b0; rr = 1'b0;
      if (i == 40) rr = 1'b1;
      if (i == 60) begin rw = 1'b1; rr = 1'b1; end
      if (i == 120) rr = 1'b1;
      if (i >= 200 && i < 1600) begin
        rw = ($urandom_range(0, 7) == 0);
        rr = ($urandom_range(0, 7) == 0);
      end
      step(rw, rr);
    end

    // Drop reset into the middle of a write burst.
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(i == 0, 1'b0);
      if (wr_data_valid === 1'b1) seen = 1'b1;
    end
    check("wr_burst_seen", seen, 1'b1);
    #1 rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    #1 check_reset_values("mid_burst_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("held_rst");
    rst = 1'b0;
    cyc = -1;
    model_reset();
    for (int i = 0; i < 200; i++) step(i == 50, i == 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
